// File: rtl/ahb_slave_responder.sv
// rtl/ahb_slave_responder.sv - memory-backed AHB subordinate with wait states; ERROR responses when AHB_SLAVE_ERROR_RESP_EN is defined
module ahb_slave_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter int HPROT_WIDTH = 4
) (
    input  logic                    i_hclk,
    input  logic                    i_hreset,
    input  logic                    i_hselx,
    input  logic [ADDR_WIDTH-1:0]   i_haddr,
    input  logic [1:0]              i_htrans,
    input  logic                    i_hwrite,
    input  logic [2:0]              i_hsize,
    input  logic [2:0]              i_hburst,
    input  logic [HPROT_WIDTH-1:0]  i_hprot,
    input  logic [DATA_WIDTH-1:0]   i_hwdata,
    input  logic [DATA_WIDTH/8-1:0] i_hwstrb,
    input  logic                    i_hready,
    output logic [DATA_WIDTH-1:0]   o_hrdata,
    output logic                    o_hreadyout,
    output logic                    o_hresp
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam int CNTW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNTW-1:0] CNT_END = CNTW'(WAIT_STATES);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNTW-1:0]         r_cnt;
    logic [CNTW-1:0]         w_cnt_nxt;
    logic [CNTW-1:0]         w_cnt_inc;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [2:0]              r_size;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_accept;
    logic                    w_can_accept;
    logic                    w_take;
    logic                    w_illegal;
    logic                    w_wr_en;
    logic [IDXW-1:0]         w_idx;
    logic                    w_unused;

    // A new address phase is only taken in cycles where this responder reports ready
    assign w_accept     = i_hselx & i_hready & i_htrans[1];
    assign w_can_accept = (r_state == ST_IDLE) | (r_state == ST_DATA) | (r_state == ST_ERR2);
    assign w_take       = w_accept & w_can_accept;
    assign w_idx        = r_addr[IDXW+OFFS-1:OFFS];
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_wr_en      = (r_state == ST_DATA) & r_write & ~i_hreset;

`ifdef AHB_SLAVE_ERROR_RESP_EN
    logic [ADDR_WIDTH-1:0] w_align_mask;
    assign w_align_mask = (ADDR_WIDTH'(1) << i_hsize) - ADDR_WIDTH'(1);
    assign w_illegal    = (|(i_haddr >> (IDXW + OFFS))) |
                          (i_hsize > 3'(OFFS)) |
                          (|(i_haddr & w_align_mask));
`else
    assign w_illegal    = 1'b0;
`endif

    // Bus fields with no effect on behaviour (burst type, protection, stored size)
    assign w_unused = ^{i_hburst, i_hprot, i_hsize, i_htrans[0], r_size, r_addr};

    // State, wait counter and registered address-phase controls
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_addr  <= i_haddr;
                r_write <= i_hwrite;
                r_size  <= i_hsize;
            end
        end
    end

    // Next state: wait-state countdown, error sequencing, pipelined acceptance from ready states
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CNT_END) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                if (w_take) begin
                    if (w_illegal) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Response outputs decoded from state; read data only in a read's final data cycle
    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        o_hrdata    = '0;
        case (r_state)
            ST_WAIT: o_hreadyout = 1'b0;
            ST_DATA: begin
                if (!r_write) begin
                    o_hrdata = r_mem[w_idx];
                end
            end
            ST_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
            end
            ST_ERR2: o_hresp = 1'b1;
            default: ;
        endcase
    end

    // Byte-masked store at the edge that ends a write's data cycle; storage is never reset
    always_ff @(posedge i_hclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_hwstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_responder.sv
// tb/tb_ahb_slave_responder.sv - scoreboard bench for ahb_slave_responder (zero-wait and two-wait instances)
module tb_ahb_slave_responder;
    logic        hclk = 1'b0;
    logic        hreset;
    logic        sel0, sel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    wire  [31:0] rdata0, rdata1;
    wire         rdy0, rdy1;
    wire         resp0, resp1;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        string       tag;
        int          inst;
        logic        rdy;
        logic        resp;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 hclk = ~hclk;

    ahb_slave_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0), .HPROT_WIDTH(4)) u0 (
        .i_hclk(hclk), .i_hreset(hreset), .i_hselx(sel0), .i_haddr(haddr), .i_htrans(htrans),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot), .i_hwdata(hwdata),
        .i_hwstrb(hwstrb), .i_hready(rdy0), .o_hrdata(rdata0), .o_hreadyout(rdy0), .o_hresp(resp0)
    );

    ahb_slave_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2), .HPROT_WIDTH(4)) u1 (
        .i_hclk(hclk), .i_hreset(hreset), .i_hselx(sel1), .i_haddr(haddr), .i_htrans(htrans),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot), .i_hwdata(hwdata),
        .i_hwstrb(hwstrb), .i_hready(rdy1), .o_hrdata(rdata1), .o_hreadyout(rdy1), .o_hresp(resp1)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic push(input string tag, input int inst, input logic rdy, input logic resp, input logic [31:0] data);
        exp_t e;
        e.tag = tag; e.inst = inst; e.rdy = rdy; e.resp = resp; e.data = data;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [33:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = (e.inst == 0) ? {rdy0, resp0, rdata0} : {rdy1, resp1, rdata1};
            n_checks++;
            assert (obs === {e.rdy, e.resp, e.data}) n_pass++;
            else $error("FAIL %s: observed rdy=%b resp=%b data=%h, expected rdy=%b resp=%b data=%h",
                        e.tag, obs[33], obs[32], obs[31:0], e.rdy, e.resp, e.data);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        @(negedge hclk);
        check();
    endtask

    task automatic addr_phase(input int inst, input logic [31:0] a, input logic wr, input logic [1:0] tr);
        sel0 = (inst == 0); sel1 = (inst == 1);
        haddr = a; hwrite = wr; htrans = tr; hsize = 3'd2;
    endtask

    task automatic idle_bus();
        sel0 = 1'b0; sel1 = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset = 1'b1; idle_bus(); hsize = 3'd2; hburst = 3'd0; hprot = 4'd0;
        hwdata = '0; hwstrb = '0;
        @(negedge hclk); @(negedge hclk);
        push("reset_u0", 0, 1'b1, 1'b0, 32'h0);
        push("reset_u1", 1, 1'b1, 1'b0, 32'h0);
        check();
        hreset = 1'b0;

        // zero-wait write then read of 0x10
        addr_phase(0, 32'h10, 1'b1, 2'd2); push("ws0_wr_dp", 0, 1'b1, 1'b0, 32'h0); step();
        hwdata = 32'hDEADBEEF; hwstrb = 4'hF;
        addr_phase(0, 32'h10, 1'b0, 2'd2); push("ws0_rd_dp", 0, 1'b1, 1'b0, 32'hDEADBEEF); step();
        idle_bus(); push("ws0_idle", 0, 1'b1, 1'b0, 32'h0); step();

        // byte strobes onto a cleared word
        addr_phase(0, 32'h20, 1'b1, 2'd2); push("strb_clr_dp", 0, 1'b1, 1'b0, 32'h0); step();
        hwdata = 32'h0; hwstrb = 4'hF;
        addr_phase(0, 32'h20, 1'b1, 2'd2); push("strb_wr_dp", 0, 1'b1, 1'b0, 32'h0); step();
        hwdata = 32'h11223344; hwstrb = 4'h5;
        addr_phase(0, 32'h20, 1'b0, 2'd2);
        push("strb_rd", 0, 1'b1, 1'b0, merge(32'h0, 32'h11223344, 4'h5)); step();
        idle_bus(); push("strb_idle", 0, 1'b1, 1'b0, 32'h0); step();

        // pipelined NONSEQ write then SEQ read of the same word
        addr_phase(0, 32'h30, 1'b1, 2'd2); push("b2b_wr_dp", 0, 1'b1, 1'b0, 32'h0); step();
        hwdata = 32'hCAFEF00D; hwstrb = 4'hF;
        addr_phase(0, 32'h30, 1'b0, 2'd3); push("b2b_rd_dp", 0, 1'b1, 1'b0, 32'hCAFEF00D); step();
        idle_bus(); push("b2b_idle", 0, 1'b1, 1'b0, 32'h0); step();

        // known value in word 0, then out-of-range write to 0x400
        addr_phase(0, 32'h0, 1'b1, 2'd2); push("w0_wr_dp", 0, 1'b1, 1'b0, 32'h0); step();
        hwdata = 32'h01020304; hwstrb = 4'hF;
        addr_phase(0, 32'h400, 1'b1, 2'd2);
`ifdef AHB_SLAVE_ERROR_RESP_EN
        push("oor_err1", 0, 1'b0, 1'b1, 32'h0); step();
        hwdata = 32'h77777777; hwstrb = 4'hF; idle_bus();
        push("oor_err2", 0, 1'b1, 1'b1, 32'h0); step();
        push("oor_idle", 0, 1'b1, 1'b0, 32'h0); step();
`else
        push("oor_dp", 0, 1'b1, 1'b0, 32'h0); step();
        hwdata = 32'h77777777; hwstrb = 4'hF; idle_bus();
        push("oor_idle", 0, 1'b1, 1'b0, 32'h0); step();
`endif
        addr_phase(0, 32'h0, 1'b0, 2'd2);
`ifdef AHB_SLAVE_ERROR_RESP_EN
        push("w0_rd", 0, 1'b1, 1'b0, 32'h01020304); step();
`else
        push("w0_rd", 0, 1'b1, 1'b0, 32'h77777777); step();
`endif
        idle_bus(); push("w0_idle", 0, 1'b1, 1'b0, 32'h0); step();

        // misaligned word read at 0x12
        addr_phase(0, 32'h12, 1'b0, 2'd2);
`ifdef AHB_SLAVE_ERROR_RESP_EN
        push("mis_err1", 0, 1'b0, 1'b1, 32'h0); step();
        idle_bus(); push("mis_err2", 0, 1'b1, 1'b1, 32'h0); step();
`else
        push("mis_dp", 0, 1'b1, 1'b0, 32'hDEADBEEF); step();
        idle_bus(); push("mis_idle", 0, 1'b1, 1'b0, 32'h0); step();
`endif
        push("mis_after", 0, 1'b1, 1'b0, 32'h0); step();

        // two-wait instance: write then read 0x10
        addr_phase(1, 32'h10, 1'b1, 2'd2); push("ws2_wr_w1", 1, 1'b0, 1'b0, 32'h0); step();
        hwdata = 32'h5A5A1234; hwstrb = 4'hF; idle_bus();
        push("ws2_wr_w2", 1, 1'b0, 1'b0, 32'h0); step();
        push("ws2_wr_dp", 1, 1'b1, 1'b0, 32'h0); step();
        addr_phase(1, 32'h10, 1'b0, 2'd2); push("ws2_rd_w1", 1, 1'b0, 1'b0, 32'h0); step();
        idle_bus(); push("ws2_rd_w2", 1, 1'b0, 1'b0, 32'h0); step();
        push("ws2_rd_dp", 1, 1'b1, 1'b0, 32'h5A5A1234); step();
        push("ws2_idle", 1, 1'b1, 1'b0, 32'h0); step();

        // reset pulse during the second wait cycle of a write
        addr_phase(1, 32'h10, 1'b1, 2'd2); push("rst_w1", 1, 1'b0, 1'b0, 32'h0); step();
        hwdata = 32'hFFFF0000; hwstrb = 4'hF; idle_bus();
        push("rst_w2", 1, 1'b0, 1'b0, 32'h0); step();
        hreset = 1'b1;
        #1;
        push("rst_now_u1", 1, 1'b1, 1'b0, 32'h0);
        push("rst_now_u0", 0, 1'b1, 1'b0, 32'h0);
        check();
        #1;
        hreset = 1'b0;
        push("rst_after", 1, 1'b1, 1'b0, 32'h0); step();
        addr_phase(1, 32'h10, 1'b0, 2'd2); push("rst_rd_w1", 1, 1'b0, 1'b0, 32'h0); step();
        idle_bus(); push("rst_rd_w2", 1, 1'b0, 1'b0, 32'h0); step();
        push("rst_rd_dp", 1, 1'b1, 1'b0, 32'h5A5A1234); step();
        push("rst_rd_idle", 1, 1'b1, 1'b0, 32'h0); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ahb_slave_responder.md
# ahb_slave_responder

Memory-backed AHB subordinate that is the responder end of the AHB interface bundle. It samples address-phase controls driven by the interconnect, inserts a configurable number of wait states, and completes each transfer with write-strobe-masked stores or read data. When the error-response feature is compiled in, it signals illegal transfers with the two-cycle AHB ERROR response. It sits behind the interconnect's subordinate port and serves as both the bench's reference responder and the target for master-side verification.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (32 or 64)
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words in internal storage (power of two)
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer (0..7)
---
- hclk  in  1  clock, all logic on rising edge
- hreset  in  1  asynchronous, active-high reset
- hselx  in  1  subordinate select
- haddr  in  ADDR_WIDTH  transfer address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write
- hsize  in  3  bytes = 2^hsize
- hburst  in  3  burst type; ignored, each beat handled independently
- hprot  in  HPROT_WIDTH  ignored
- hwdata  in  DATA_WIDTH  write data (data phase)
- hwstrb  in  DATA_WIDTH/8  byte lane enables (data phase)
- hready  in  1  bus ready; qualifies address phase
- hrdata  out  DATA_WIDTH  read data
- hreadyout  out  1  transfer-done indication
- hresp  out  1  0=OKAY, 1=ERROR

## Operation
- Transfer accepted when hselx & hready & htrans[1] on a rising edge. haddr, hwrite, and hsize are registered.
- IDLE/BUSY or deselected cycles: no state change and a zero-wait OKAY.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE→WAIT: accepted and WAIT_STATES>0.
  - IDLE→DATA: accepted and WAIT_STATES=0.
  - WAIT→DATA: when the wait counter reaches WAIT_STATES.
  - DATA→IDLE, or DATA→WAIT/DATA when a new transfer is accepted in the same cycle (pipelined back-to-back).
  - IDLE/DATA→ERR1: accepted transfer is illegal (feature enabled only).
  - ERR1→ERR2 unconditionally.
  - ERR2 behaves like DATA for accepting the next transfer.
- Word index = registered haddr[log2(MEM_DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]. Higher address bits are ignored when error feature is disabled (address wraps modulo storage size).
- Write: in the DATA cycle (hreadyout=1), each byte lane with hwstrb set is stored at the clock edge ending the cycle.
- Read: hrdata = mem[index] during the DATA cycle; 0 in all other cycles.
- A read immediately following a write to the same word returns the new data, because the store completes at the edge that begins the read's data phase.
- Wait counter is $clog2(WAIT_STATES+1) bits; cleared on entering WAIT.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, counter=0. Memory contents are not reset.
- Reset asserted mid-transfer: transfer abandoned, no memory write, outputs take reset values immediately.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles. hreadyout=0 for the first WAIT_STATES cycles and 1 in the last. hresp=0 throughout.
- ERROR: ERR1 drives hreadyout=0, hresp=1; ERR2 drives hreadyout=1, hresp=1. No wait states are inserted before ERR1. Errored writes are not committed. Errored reads drive hrdata=0.
- hselx deasserted during a data phase does not affect the in-flight transfer.

## Configuration
- AHB_SLAVE_ERROR_RESP_EN defined: the following transfers are illegal and produce the two-cycle ERROR response:
  - haddr ≥ MEM_DEPTH*DATA_WIDTH/8;
  - hsize > log2(DATA_WIDTH/8);
  - haddr not aligned to 2^hsize.
- Undefined: every accepted transfer completes OKAY. Out-of-range addresses wrap. Oversize or misaligned transfers use the word index and hwstrb unchanged. ERR1/ERR2 are unreachable.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 with hwstrb=0xF, then read 0x10 → hreadyout stays 1, hrdata=0xDEADBEEF in the cycle after the read address phase.
- WAIT_STATES=2: read 0x10 → hreadyout 0,0,1 over three cycles, data valid on the third, hresp=0.
- Byte strobes: write 0x11223344 to 0x20 with hwstrb=0x5 onto a word holding 0 → readback 0x00220044.
- Back-to-back pipelined: NONSEQ write 0x30, then SEQ read 0x30 presented during the write data phase → read returns the written value with no extra cycle.
- Error enabled, MEM_DEPTH=256: write to 0x400 → ERR1 (hreadyout=0, hresp=1), ERR2 (hreadyout=1, hresp=1), memory unchanged. Same stimulus with the macro undefined → OKAY, word 0 updated.
- hreset pulsed during the second wait cycle of a write → hreadyout=1, hresp=0 immediately, target word unchanged.
